// File: rtl/hex_display_pager_pkg.sv
// Shared types and defaults for the hex display pager: page-state encoding,
// default dwell/gap lengths and the dwell counter width helper.
package hex_pager_pkg;

    typedef enum logic [1:0] {
        S_LO     = 2'b00,
        S_GAP_HI = 2'b01,
        S_HI     = 2'b10,
        S_GAP_LO = 2'b11
    } pager_state_t;

    localparam int DWELL_DEFAULT = 5_000_000;
    localparam int GAP_DEFAULT   = 500_000;

    // One counter serves both show and gap states, so it is sized for the longer one.
    function automatic int cnt_width(input int dwell, input int gap);
        int longest;
        longest = (dwell > gap) ? dwell : gap;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/hex_display_pager_if.sv
// Word-in / halfword-out bundle between the CPU-side source and the pager.
interface hex_display_pager_if;
    logic [31:0] word_in;
    logic        word_valid;
    logic        freeze;
    logic [15:0] hex_val;
    logic        page;
    logic        blank;

    modport master (
        output word_in, word_valid, freeze,
        input  hex_val, page, blank
    );

    modport slave (
        input  word_in, word_valid, freeze,
        output hex_val, page, blank
    );
endinterface

// File: rtl/hex_display_pager_dwell_timer.sv
// Terminal-count timer: counts 0..term, pulses expire while at term and
// wraps to zero on that edge; clear restarts the count from zero.
module dwell_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] term,
    output logic             expire
);

    logic [CNT_W-1:0] count_reg;

    assign expire = (count_reg == term);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear || expire) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hex_display_pager.sv
// Snapshots a 32-bit word and pages its low/high halfwords onto hex_val.
// Define HEX_PAGER_BLANK_GAP_EN to insert blank gap states between pages.
module hex_display_pager
    import hex_pager_pkg::*;
#(
    parameter int DWELL_CYCLES = DWELL_DEFAULT,
    parameter int GAP_CYCLES   = GAP_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    hex_display_pager_if.slave        bus
);

    localparam int               CNT_W      = cnt_width(DWELL_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_TERM = CNT_W'(DWELL_CYCLES - 1);

    pager_state_t     state_reg;
    logic [31:0]      snap_reg;
    logic [15:0]      hex_reg;
    logic             page_reg;
    logic             capture;
    logic             restart;
    logic             expire;
    logic [CNT_W-1:0] term_cnt;

    assign capture = bus.word_valid && !bus.freeze;
    assign restart = capture && (bus.word_in != snap_reg);

`ifdef HEX_PAGER_BLANK_GAP_EN
    localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(GAP_CYCLES - 1);
    logic blank_reg;

    assign term_cnt = (state_reg == S_LO || state_reg == S_HI) ? DWELL_TERM : GAP_TERM;
    assign bus.blank = blank_reg;
`else
    assign term_cnt  = DWELL_TERM;
    assign bus.blank = 1'b0;
`endif

    assign bus.hex_val = hex_reg;
    assign bus.page    = page_reg;

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (restart),
        .term   (term_cnt),
        .expire (expire)
    );

    // A changed word outranks expiry so the new low half is always shown first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_LO;
            snap_reg  <= '0;
            hex_reg   <= '0;
            page_reg  <= 1'b0;
`ifdef HEX_PAGER_BLANK_GAP_EN
            blank_reg <= 1'b0;
`endif
        end else begin
            if (capture) begin
                snap_reg <= bus.word_in;
            end
            if (restart) begin
                state_reg <= S_LO;
                hex_reg   <= bus.word_in[15:0];
                page_reg  <= 1'b0;
`ifdef HEX_PAGER_BLANK_GAP_EN
                blank_reg <= 1'b0;
`endif
            end else if (expire) begin
                case (state_reg)
`ifdef HEX_PAGER_BLANK_GAP_EN
                    S_LO: begin
                        state_reg <= S_GAP_HI;
                        blank_reg <= 1'b1;
                    end
                    S_GAP_HI: begin
                        state_reg <= S_HI;
                        hex_reg   <= snap_reg[31:16];
                        page_reg  <= 1'b1;
                        blank_reg <= 1'b0;
                    end
                    S_HI: begin
                        state_reg <= S_GAP_LO;
                        blank_reg <= 1'b1;
                    end
                    default: begin
                        state_reg <= S_LO;
                        hex_reg   <= snap_reg[15:0];
                        page_reg  <= 1'b0;
                        blank_reg <= 1'b0;
                    end
`else
                    S_LO: begin
                        state_reg <= S_HI;
                        hex_reg   <= snap_reg[31:16];
                        page_reg  <= 1'b1;
                    end
                    default: begin
                        state_reg <= S_LO;
                        hex_reg   <= snap_reg[15:0];
                        page_reg  <= 1'b0;
                    end
`endif
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hex_display_pager.sv
// Scoreboard bench for hex_display_pager with DWELL=4, GAP=2; works with the
// gap feature either compiled in or out.
module tb_hex_display_pager;

    localparam int DWELL = 4;
    localparam int GAP   = 2;
`ifdef HEX_PAGER_BLANK_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    hex_display_pager_if pif ();

    hex_display_pager #(
        .DWELL_CYCLES (DWELL),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hex;
        logic        page;
        logic        blank;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   step_id = 0;

    task automatic compare(input string name, input int id,
                           input logic [17:0] act, input logic [17:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s #%0d: got hex=%h page=%b blank=%b, want hex=%h page=%b blank=%b",
                     name, id, act[17:2], act[1], act[0], req[17:2], req[1], req[0]);
        end else begin
            $display("ok   %s #%0d: hex=%h page=%b blank=%b", name, id, act[17:2], act[1], act[0]);
        end
    endtask

    // Drive one cycle of inputs (entered at a negedge) and queue the outputs
    // expected right after the following posedge.
    task automatic step(input logic v, input logic f, input logic [31:0] w,
                        input logic [15:0] h, input logic p, input logic b);
        exp_t e;
        pif.word_valid = v;
        pif.freeze     = f;
        pif.word_in    = w;
        e.hex   = h;
        e.page  = p;
        e.blank = b;
        e.id    = step_id;
        step_id++;
        exp_q.push_back(e);
        @(negedge clk);
        pif.word_valid = 1'b0;
        pif.freeze     = 1'b0;
    endtask

    task automatic run(input int n, input logic [15:0] h, input logic p);
        repeat (n) step(1'b0, 1'b0, 32'h0, h, p, 1'b0);
    endtask

    task automatic gap(input int n, input logic [15:0] h, input logic p);
        repeat (GAP_EN ? n : 0) step(1'b0, 1'b0, 32'h0, h, p, 1'b1);
    endtask

    // Monitor: one popped expectation per clock once stimulus is queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("page_seq", e.id, {pif.hex_val, pif.page, pif.blank},
                        {e.hex, e.page, e.blank});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        pif.word_in    = 32'h0;
        pif.word_valid = 1'b0;
        pif.freeze     = 1'b0;
        repeat (2) @(negedge clk);
        compare("reset_state", -1, {pif.hex_val, pif.page, pif.blank}, 18'h0);
        reset = 1'b0;

        step(1'b0, 1'b0, 32'h0,        16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h1234ABCD, 16'hABCD, 1'b0, 1'b0);
        run(3, 16'hABCD, 1'b0);
        gap(2, 16'hABCD, 1'b0);
        run(4, 16'h1234, 1'b1);
        gap(2, 16'h1234, 1'b1);
        run(4, 16'hABCD, 1'b0);
        gap(2, 16'hABCD, 1'b0);
        // Same word re-sent mid S_HI: no restart
        run(1, 16'h1234, 1'b1);
        step(1'b1, 1'b0, 32'h1234ABCD, 16'h1234, 1'b1, 1'b0);
        run(2, 16'h1234, 1'b1);
        gap(2, 16'h1234, 1'b1);
        run(4, 16'hABCD, 1'b0);
        gap(2, 16'hABCD, 1'b0);
        // New word mid S_HI restarts on the low half
        run(2, 16'h1234, 1'b1);
        step(1'b1, 1'b0, 32'hDEADBEEF, 16'hBEEF, 1'b0, 1'b0);
        run(3, 16'hBEEF, 1'b0);
        gap(2, 16'hBEEF, 1'b0);
        // Frozen word is ignored
        run(1, 16'hDEAD, 1'b1);
        step(1'b1, 1'b1, 32'hFFFFFFFF, 16'hDEAD, 1'b1, 1'b0);
        run(2, 16'hDEAD, 1'b1);
        gap(2, 16'hDEAD, 1'b1);
        run(4, 16'hBEEF, 1'b0);
        // Change on the expiring edge of the gap (or of S_LO without gaps)
        gap(2, 16'hBEEF, 1'b0);
        step(1'b1, 1'b0, 32'h12345678, 16'h5678, 1'b0, 1'b0);
        run(3, 16'h5678, 1'b0);
        gap(2, 16'h5678, 1'b0);
        run(2, 16'h1234, 1'b1);

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d queued, want 0", exp_q.size());
        end

        // Asynchronous reset mid-page, away from any clock edge
        #3;
        reset = 1'b1;
        #1;
        compare("async_reset", -2, {pif.hex_val, pif.page, pif.blank}, 18'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First S_LO after release lasts the full dwell
        run(3, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 32'h0, 16'h0000, GAP_EN ? 1'b0 : 1'b1, GAP_EN ? 1'b1 : 1'b0);

        repeat (2) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_display_pager.md
# hex_display_pager

Upstream feeder for the four-digit hex display. Takes a 32-bit word from the CPU side (instruction or memory output) and presents it 16 bits at a time. It snapshots the word on a valid strobe, then alternates between the low and high halfwords on a fixed dwell period. An optional blank gap between pages lets the viewer tell the two halves apart. Runs in the CPU clock domain; its `hex_val` output drives the display's `hex_val` input.

## Interface
- `DWELL_CYCLES`, default 5_000_000: cycles each halfword is shown (1 s at 5 MHz); must be ≥ 2.
- `GAP_CYCLES`, default 500_000: cycles of blank between pages; must be ≥ 1; used only with the gap feature.
- `clk`, input, 1: CPU clock (clk5 domain).
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `word_in`, input, 32: word to display.
- `word_valid`, input, 1: sample `word_in` on this edge.
- `freeze`, input, 1: when high, the snapshot is not updated; paging continues.
- `hex_val`, output, 16: halfword for the display.
- `page`, output, 1: 0 = low halfword shown, 1 = high halfword shown.
- `blank`, output, 1: high while in a gap state; the wrapper gates the anodes with it.

## Operation
- Reset values: snapshot 0, state S_LO, counter 0, `hex_val` 0, `page` 0, `blank` 0.
- Snapshot: on an edge with `word_valid`=1 and `freeze`=0, snap ← `word_in`.
- Change restart: if the captured word differs from the current snap, the state is forced to S_LO and the counter is cleared.
  - A captured word equal to snap causes no restart.
- States and transitions:
  - S_LO → S_GAP_HI → S_HI → S_GAP_LO → S_LO.
  - Show states last exactly DWELL_CYCLES; the counter runs 0..DWELL_CYCLES-1 and the state transitions on count = DWELL_CYCLES-1.
  - Gap states last exactly GAP_CYCLES.
  - The counter clears on every transition.
- Outputs per state:
  - S_LO: `hex_val` = snap[15:0], `page` 0, `blank` 0.
  - S_HI: `hex_val` = snap[31:16], `page` 1, `blank` 0.
  - Gap states: `blank` 1; `hex_val` and `page` hold their previous values.
- Priority: a change restart beats dwell or gap expiry in the same cycle. This includes a restart during a gap, which lands in S_LO with `blank` 0.
- `freeze`=1 together with `word_valid`=1: the word is ignored and no restart occurs.
- Counter width is $clog2(max(DWELL_CYCLES, GAP_CYCLES)). The counter never wraps; it is cleared at the terminal count.

## Timing
- `hex_val`, `page` and `blank` are registers updated on the same edge as the state register. Each reflects the state entered on that edge.
- Latency: `word_valid` sampled at edge E gives the new low halfword on `hex_val` after edge E (1 cycle), provided the word changed.
- `hex_val` changes at most once per DWELL_CYCLES in steady state. This lets the 100 MHz display sample it without a synchronizer; an isolated glitch frame is acceptable.
- Reset asserted mid-page returns all outputs to reset values asynchronously. The first S_LO after reset release lasts the full DWELL_CYCLES.

## Configuration
- `HEX_PAGER_BLANK_GAP_EN` defined:
  - Gap states are present and `blank` behaves as above.
  - GAP_CYCLES applies.
- Not defined:
  - Transitions are S_LO → S_HI → S_LO directly.
  - `blank` is tied to 0.
  - GAP_CYCLES is ignored.

## Structure
- Shared package `hex_pager_pkg` holds:
  - the state encoding (S_LO, S_GAP_HI, S_HI, S_GAP_LO);
  - default constants DWELL_DEFAULT and GAP_DEFAULT.
- One sub-module, `dwell_timer`:
  - loadable terminal-count counter with a clear input;
  - outputs a one-cycle `expire` pulse.
- The top level holds the snapshot register, change compare, state register and output registers.

## Test plan
All scenarios use DWELL_CYCLES=4 and GAP_CYCLES=2, with the gap feature enabled unless stated.
- Reset, then `word_valid` with 0x1234ABCD → next cycle `hex_val`=0xABCD, `page`=0.
  - After 4 cycles `blank`=1 for 2 cycles.
  - Then `hex_val`=0x1234, `page`=1 for 4 cycles; sequence repeats.
- In S_HI, `word_valid` with 0xDEADBEEF → next cycle `hex_val`=0xBEEF, `page`=0, full 4-cycle dwell.
- Same word 0x1234ABCD re-sent during S_HI → no restart; S_HI completes its 4 cycles.
- `freeze`=1 with `word_valid` and 0xFFFFFFFF → snap unchanged and paging unaffected.
- Change arriving on the last gap cycle → S_LO with `blank`=0 and the new low half shown.
- Reset asserted mid-dwell → outputs go to 0 immediately, without waiting for a clock edge.
- Gap feature compiled out → direct 4/4-cycle alternation and `blank` constantly 0.
